// File: rtl/and_ff_arbiter.sv
// and_ff_arbiter
//   Round-robin arbiter that shares one registered AND unit (and_ff) among
//   NUM_REQ requesters. A request is accepted in IDLE, its operands are issued
//   to the unit for one cycle, the unit's registered result is captured, and
//   the result is then held for the granted requester until that requester
//   accepts it.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   req_valid  : per-requester operation request
//   req_a/b    : per-requester operand bits
//   req_ready  : one-hot accept strobe (only in the accepting IDLE cycle)
//   rsp_valid  : one-hot result-valid towards the granted requester
//   rsp_z      : shared result bit, meaningful only with rsp_valid
//   rsp_ready  : per-requester result acceptance
//   ff_rst_n   : active-low reset to the and_ff unit (~rst)
//   ff_enable  : and_ff enable, high only in ISSUE
//   ff_a/ff_b  : and_ff operands, zero outside ISSUE
//   ff_z       : registered result from the and_ff unit
//   busy       : high whenever the FSM is not IDLE
//   op_count   : saturating count of completed operations
module and_ff_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_a,
  input  logic [NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic               rsp_z,
  input  logic [NUM_REQ-1:0] rsp_ready,
  output logic               ff_rst_n,
  output logic               ff_enable,
  output logic               ff_a,
  output logic               ff_b,
  input  logic               ff_z,
  output logic               busy,
  output logic [15:0]        op_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   r_last_grant;
  logic               r_ff_enable;
  logic               r_ff_a;
  logic               r_ff_b;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_rsp_z;
  logic [15:0]        r_op_count;

  logic               w_found;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [IDX_W-1:0]   w_cand;

  // Round-robin search: start one past the last served requester and take
  // the first pending bit, wrapping modulo NUM_REQ.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_last_grant) + 1 + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  // The accept strobe has to be combinational so the requester sees it in the
  // same cycle its operands are latched; it is forced low while in reset.
  assign req_ready = (r_state == S_IDLE && w_found && !rst)
                     ? (NUM_REQ'(1) << w_grant_idx) : '0;

  assign ff_rst_n  = ~rst;
  assign ff_enable = r_ff_enable;
  assign ff_a      = r_ff_a;
  assign ff_b      = r_ff_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_z     = r_rsp_z;
  assign busy      = (r_state != S_IDLE);
  assign op_count  = r_op_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_ff_enable  <= 1'b0;
      r_ff_a       <= 1'b0;
      r_ff_b       <= 1'b0;
      r_rsp_valid  <= '0;
      r_rsp_z      <= 1'b0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            // Operands go straight into the unit drive registers, so a
            // requester dropping its request later cannot disturb them.
            r_grant     <= w_grant_idx;
            r_ff_enable <= 1'b1;
            r_ff_a      <= req_a[w_grant_idx];
            r_ff_b      <= req_b[w_grant_idx];
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_ff_enable <= 1'b0;
          r_ff_a      <= 1'b0;
          r_ff_b      <= 1'b0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          // The unit registered a&b at the end of ISSUE; ff_z is valid now.
          r_rsp_z     <= ff_z;
          r_rsp_valid <= NUM_REQ'(1) << r_grant;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready[r_grant]) begin
            r_rsp_valid  <= '0;
            r_last_grant <= r_grant;
            if (r_op_count != 16'hFFFF) begin
              r_op_count <= r_op_count + 16'd1;
            end
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/and_ff_arbiter.md
AND_FF_ARBITER -- requirements
Module: and_ff_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one and_ff unit (2..8).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req_valid  input  NUM_REQ  per-requester operation request.
REQ-005 Port: req_a, req_b  input  NUM_REQ each  per-requester operand bits.
REQ-006 Port: req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-007 Port: rsp_valid  output  NUM_REQ  one-hot result-valid to the granted requester.
REQ-008 Port: rsp_z  output  1  result bit, shared by all requesters, meaningful only with rsp_valid.
REQ-009 Port: rsp_ready  input  NUM_REQ  per-requester result acceptance.
REQ-010 Port: ff_rst_n  output  1  active-low reset to the and_ff unit, equal to ~rst (combinational).
REQ-011 Port: ff_enable, ff_a, ff_b  output  1 each  drive to the and_ff unit.
REQ-012 Port: ff_z  input  1  registered result from the and_ff unit.
REQ-013 Port: busy  output  1  high in any state other than IDLE.
REQ-014 Port: op_count  output  16  completed-operation counter.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE: if any req_valid bit is high, select winner g by round-robin, starting the search at last_grant+1 modulo NUM_REQ and taking the first set bit.
REQ-017 In that IDLE cycle, req_ready SHALL be one-hot at bit g; req_a[g], req_b[g] and g SHALL be latched; next state is ISSUE.
REQ-018 req_ready SHALL be all-zero in every state except the accepting IDLE cycle.
REQ-019 ISSUE: ff_enable=1; ff_a and ff_b SHALL drive the latched operands; next state is WAIT.
REQ-020 In all states other than ISSUE, ff_enable=0 and ff_a=ff_b=0.
REQ-021 WAIT: capture ff_z into the rsp_z register; next state is RESP.
REQ-022 RESP: rsp_valid[g]=1, with rsp_z held stable, until rsp_ready[g]=1; rsp_ready on other bits SHALL be ignored.
REQ-023 RESP exit on rsp_ready[g]: last_grant<=g; op_count increments; next state is IDLE.
REQ-024 The RESP exit cycle SHALL NOT itself accept a new request. Minimum cycles from accept to next accept is 4.
REQ-025 Latency: accept at cycle T → ff_enable at T+1 → rsp_valid first high at T+3.
REQ-026 op_count SHALL saturate at 16'hFFFF; it SHALL NOT wrap.
REQ-027 A requester dropping req_valid after acceptance SHALL NOT affect the in-flight operation.
REQ-028 Simultaneous requests SHALL be served in round-robin order, with no requester starved while it holds req_valid.
REQ-029 With last_grant = NUM_REQ-1, the search SHALL wrap to bit 0.

Reset
REQ-030 While rst=1, asynchronously: state=IDLE; req_ready=0; rsp_valid=0; rsp_z=0; ff_enable=ff_a=ff_b=0; busy=0; op_count=0; last_grant=NUM_REQ-1 (so bit 0 wins first).
REQ-031 Reset asserted mid-operation SHALL abandon the operation with no response; ff_rst_n=0 for the whole reset.
REQ-032 After rst deasserts, the first accept SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-033 Single request: req_valid=4'b0010, a=1, b=1 → req_ready=0010 at T; ff_enable=1 with ff_a=ff_b=1 at T+1; rsp_valid=0010 with rsp_z=1 at T+3; op_count=1.
REQ-034 All-ones contention: req_valid=4'b1111 held, rsp_ready all 1, from reset → grant order 0,1,2,3,0; accepts spaced exactly 4 cycles apart.
REQ-035 Backpressure: rsp_ready[g]=0 for 5 cycles → rsp_valid and rsp_z stable for 5 cycles; req_ready stays 0; exit one cycle after rsp_ready rises.
REQ-036 Exhaustive operands: all four a/b combinations on requester 3 → rsp_z equals a&b each time.
REQ-037 Reset mid-operation: rst pulsed during WAIT → all outputs at reset values immediately; ff_rst_n=0; no rsp_valid follows; the next grant goes to the lowest pending bit.
REQ-038 Saturation: op_count forced to 16'hFFFE, then 3 completed operations → op_count reads 16'hFFFF.
